// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing helpers for the shift-and-add multiplier
//   state_t : controller states IDLE / BUSY / DONE
//   count_w : width of a counter that must hold 0..width inclusive
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rca_adder.sv
// rtl/rca_adder.sv - N-bit ripple-carry adder built from 1-bit full-adder cells
//   a, b : N-bit addends
//   cin  : carry into bit 0
//   sum  : N-bit sum
//   cout : carry out of bit N-1
module rca_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_carry[N];

endmodule

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - unsigned WIDTH x WIDTH sequential shift-and-add multiplier
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b sampled on the accepting edge)
//   out_valid/out_ready : product handshake (product held while out_valid)
//   busy                : high while bits are being retired
//   EARLY_TERM_EN       : when defined, finish as soon as no multiplier bits remain
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = count_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mult;
  logic [CW-1:0]   r_count;

  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_sum;
  logic            w_unused_cout;
  logic            w_last;

  assign w_addend = r_mult[0] ? r_mcand : '0;

  // The product always fits in 2*WIDTH bits, so the carry out is never set.
  rca_adder #(.N(PW)) u_adder (
    .a    (r_acc),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_unused_cout)
  );

`ifdef EARLY_TERM_EN
  // Once the remaining multiplier bits above bit 0 are all zero, this step is the last one.
  assign w_last = (r_count == LAST) || (r_mult[WIDTH-1:1] == '0);
`else
  assign w_last = (r_count == LAST);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    product     = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        product   = r_acc;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mult  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, a};
            r_mult  <= b;
            r_count <= '0;
          end
        end
        BUSY: begin
          r_acc   <= w_sum;
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_count <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
